// File: rtl/and_gate_cosim_proxy_pkg.sv
// rtl/and_gate_cosim_proxy_pkg.sv - shared types and defaults for the AND-gate co-simulation proxy
package and_gate_proxy_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/and_gate_cosim_proxy_if.sv
// rtl/and_gate_cosim_proxy_if.sv - request/response channel to the external co-simulated AND model
interface and_gate_cosim_proxy_if;

  logic req_valid;
  logic req_ready;
  logic req_a;
  logic req_b;
  logic rsp_valid;
  logic rsp_y;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_y
  );

endinterface

// File: rtl/and_gate_cosim_checker.sv
// rtl/and_gate_cosim_checker.sv - forwards input changes to the external model and checks its answers
module and_gate_cosim_checker
  import and_gate_proxy_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  and_gate_cosim_proxy_if.master cosim,
  output logic                  mismatch,
  output logic                  timeout,
  output logic [CNT_W-1:0]      txn_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [1:0]      ab_q;
  logic [1:0]      last_q, last_d;
  logic            first_q;
  logic            pending_q, pending_d;
  logic            req_a_d, req_b_d;
  logic            exp_q, exp_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic            mismatch_d, timeout_d;
  logic [CNT_W-1:0] txn_d;

  assign cosim.req_valid = (state_q == REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ab_q        <= 2'b00;
      last_q      <= 2'b00;
      first_q     <= 1'b1;
      pending_q   <= 1'b0;
      cosim.req_a <= 1'b0;
      cosim.req_b <= 1'b0;
      exp_q       <= 1'b0;
      wcnt_q      <= '0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
      txn_count   <= '0;
    end else begin
      state_q     <= state_d;
      ab_q        <= {a, b};
      last_q      <= last_d;
      first_q     <= 1'b0;
      pending_q   <= pending_d;
      cosim.req_a <= req_a_d;
      cosim.req_b <= req_b_d;
      exp_q       <= exp_d;
      wcnt_q      <= wcnt_d;
      mismatch    <= mismatch_d;
      timeout     <= timeout_d;
      txn_count   <= txn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    req_a_d    = cosim.req_a;
    req_b_d    = cosim.req_b;
    exp_d      = exp_q;
    wcnt_d     = wcnt_q;
    mismatch_d = mismatch;
    timeout_d  = timeout;
    txn_d      = txn_count;
    // Changes seen while busy accumulate here and are sent once back in IDLE
    pending_d  = pending_q | first_q | (ab_q != last_q);
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          req_a_d   = ab_q[1];
          req_b_d   = ab_q[0];
          exp_d     = ab_q[1] & ab_q[0];
          last_d    = ab_q;
          pending_d = 1'b0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (cosim.req_ready) begin
          wcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still counts as a response
        if (cosim.rsp_valid) begin
          if (cosim.rsp_y != exp_q) mismatch_d = 1'b1;
          if (txn_count != '1) txn_d = txn_count + 1'b1;
          state_d = IDLE;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/and_gate_cosim_proxy.sv
// rtl/and_gate_cosim_proxy.sv - combinational AND gate shadowed by an external co-simulation check
module and_gate_cosim_proxy
  import and_gate_proxy_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  output logic                  y,
  and_gate_cosim_proxy_if.master cosim,
  output logic                  mismatch,
  output logic                  timeout,
  output logic [CNT_W-1:0]      txn_count
);

  // y never touches clocked state so the gate works with clk/rst undriven
  assign y = a & b;

  and_gate_cosim_checker #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cosim     (cosim),
    .mismatch  (mismatch),
    .timeout   (timeout),
    .txn_count (txn_count)
  );

endmodule

// File: tb/tb_and_gate_cosim_proxy.sv
// tb/tb_and_gate_cosim_proxy.sv - self-checking bench for and_gate_cosim_proxy
module tb_and_gate_cosim_proxy;
  import and_gate_proxy_pkg::*;

  localparam int TO = TIMEOUT_DEF;

  logic clk;
  logic rst;
  logic a, b, y;
  logic mismatch, timeout;
  logic [CNT_W_DEF-1:0] txn_count;
  bit   clk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  and_gate_cosim_proxy_if cosim_if ();

  and_gate_cosim_proxy dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .y         (y),
    .cosim     (cosim_if),
    .mismatch  (mismatch),
    .timeout   (timeout),
    .txn_count (txn_count)
  );

  initial begin
    wait (clk_en);
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic a;
    logic b;
    logic y;
  } vec_t;

  vec_t tt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cosim_if.req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_req_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic respond(input logic v);
    cosim_if.rsp_valid = 1'b1;
    cosim_if.rsp_y     = v;
    @(negedge clk);
    cosim_if.rsp_valid = 1'b0;
  endtask

  int   exp_txn;
  bit   exp_mis;
  bit   busy, rsp_fired, rsp_wrong, hold_prev, rdy;
  int   cnt, extra;
  logic exp_y;
  logic [1:0] prev_pair, last_pair;

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b1};
    cosim_if.req_ready = 1'b0;
    cosim_if.rsp_valid = 1'b0;
    cosim_if.rsp_y     = 1'b0;

    // Truth table with clk and rst left undriven
    for (int i = 0; i < 4; i++) begin
      a = tt[i].a;
      b = tt[i].b;
      #1;
      chk($sformatf("truth_%0d", i), 32'(y), 32'(tt[i].y));
    end

    // Reset state
    a = 1'b1; b = 1'b1; rst = 1'b1;
    #1;
    chk("rst_req_valid", 32'(cosim_if.req_valid), 0);
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_txn", 32'(txn_count), 0);
    chk("rst_y", 32'(y), 1);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_y_clocked", 32'(y), 1);
    rst = 1'b0;
    exp_txn = 0;

    // Basic handshake with a correct answer
    cosim_if.req_ready = 1'b1;
    wait_req("hs", 10);
    chk("hs_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b11);
    @(negedge clk);
    chk("hs_req_drop", 32'(cosim_if.req_valid), 0);
    respond(1'b1);
    exp_txn++;
    chk("hs_txn", 32'(txn_count), 32'(exp_txn));
    chk("hs_mismatch", 32'(mismatch), 0);

    // Wrong answer sets a sticky mismatch
    a = 1'b1; b = 1'b0;
    wait_req("mis", 10);
    chk("mis_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b10);
    @(negedge clk);
    respond(1'b1);
    exp_txn++;
    chk("mis_flag", 32'(mismatch), 1);
    chk("mis_txn", 32'(txn_count), 32'(exp_txn));
    a = 1'b1; b = 1'b1;
    wait_req("mis2", 10);
    @(negedge clk);
    respond(1'b1);
    exp_txn++;
    chk("mis_sticky", 32'(mismatch), 1);
    chk("mis2_txn", 32'(txn_count), 32'(exp_txn));

    // Timeout after exactly TO cycles in WAIT
    a = 1'b0; b = 1'b1;
    wait_req("to", 10);
    chk("to_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b01);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    chk("to_not_yet", 32'(timeout), 0);
    @(negedge clk);
    chk("to_flag", 32'(timeout), 1);
    chk("to_txn", 32'(txn_count), 32'(exp_txn));
    a = 1'b1; b = 1'b1;
    wait_req("to_idle", 10);
    chk("to_idle_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b11);
    @(negedge clk);
    respond(1'b1);
    exp_txn++;
    chk("to_after_txn", 32'(txn_count), 32'(exp_txn));

    // Back-pressure while inputs move underneath the held request
    cosim_if.req_ready = 1'b0;
    a = 1'b0; b = 1'b0;
    wait_req("bp", 10);
    chk("bp_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b00);
    a = 1'b1; b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", i),
          32'({cosim_if.req_valid, cosim_if.req_a, cosim_if.req_b}), 32'b100);
    end
    cosim_if.req_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(cosim_if.req_valid), 0);
    respond(1'b0);
    exp_txn++;
    wait_req("bp_follow", 10);
    chk("bp_follow_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b11);
    @(negedge clk);
    respond(1'b1);
    exp_txn++;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (cosim_if.req_valid === 1'b1) extra++;
    end
    chk("bp_single_followup", 32'(extra), 0);
    chk("bp_txn", 32'(txn_count), 32'(exp_txn));

    // Randomised traffic against a transaction-level model of the external side
    a = 1'b0; b = 1'b0;
    cosim_if.req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rnd_rst_flags", 32'({mismatch, timeout}), 0);
    rst = 1'b0;
    exp_txn = 0; exp_mis = 1'b0;
    wait_req("first_after_rst", 10);
    chk("first_pair", 32'({cosim_if.req_a, cosim_if.req_b}), 32'b00);
    busy = 1'b0; rsp_fired = 1'b0; rsp_wrong = 1'b0;
    hold_prev = 1'b0; prev_pair = 2'b00; last_pair = 2'b00; cnt = 0;
    for (int cyc = 0; cyc < 3040; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (rsp_fired) begin
        exp_txn++;
        exp_mis = exp_mis | rsp_wrong;
        chk("rnd_txn", 32'(txn_count), 32'(exp_txn));
        chk("rnd_mismatch", 32'(mismatch), 32'(exp_mis));
        rsp_fired = 1'b0;
      end
      cosim_if.rsp_valid = 1'b0;
      chk("rnd_y", 32'(y), 32'(a & b));
      if (hold_prev)
        chk("rnd_hold", 32'({cosim_if.req_valid, cosim_if.req_a, cosim_if.req_b}),
            32'({1'b1, prev_pair}));
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          rsp_wrong          = ($urandom_range(0, 15) == 0);
          cosim_if.rsp_valid = 1'b1;
          cosim_if.rsp_y     = exp_y ^ rsp_wrong;
          rsp_fired          = 1'b1;
          busy               = 1'b0;
        end
      end
      if (cyc < 3000 && $urandom_range(0, 3) == 0) {a, b} = 2'($urandom);
      rdy = (cyc >= 3000) || ($urandom_range(0, 2) != 0);
      cosim_if.req_ready = rdy;
      prev_pair = {cosim_if.req_a, cosim_if.req_b};
      if (cosim_if.req_valid === 1'b1 && rdy) begin
        busy      = 1'b1;
        cnt       = $urandom_range(1, TO - 1);
        exp_y     = cosim_if.req_a & cosim_if.req_b;
        last_pair = {cosim_if.req_a, cosim_if.req_b};
        hold_prev = 1'b0;
      end else begin
        hold_prev = (cosim_if.req_valid === 1'b1);
      end
    end
    chk("rnd_final_txn", 32'(txn_count), 32'(exp_txn));
    chk("rnd_final_mismatch", 32'(mismatch), 32'(exp_mis));
    chk("rnd_final_timeout", 32'(timeout), 0);
    chk("rnd_last_pair", 32'(last_pair), 32'({a, b}));
    chk("rnd_quiet", 32'(cosim_if.req_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
